// File: rtl/sfq_delay_line.sv
// sfq_delay_line: per-channel SFQ pulse delay line.
// Each channel is a DEPTH-stage shift register of single-bit pulse slots
// followed by a registered output pulse. The block also keeps a saturating
// count of emitted pulses and a sticky flag for discarded inputs.
// Modes: DELAY shifts, HOLD freezes the stages and repeats the last slot,
// FLUSH clears everything in flight. Mode 11 is an alias of DELAY.
module sfq_delay_line #(
  parameter int CH    = 4,
  parameter int DEPTH = 3,
  parameter int CW    = 8
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic [CH-1:0]    in_pulse,
  input  logic [1:0]       mode,
  output logic [CH-1:0]    out_pulse,
  output logic [CH*CW-1:0] out_cnt,
  output logic [CH-1:0]    drop,
  output logic             busy
);

  localparam logic [1:0] MODE_DELAY = 2'b00;
  localparam logic [1:0] MODE_HOLD  = 2'b01;
  localparam logic [1:0] MODE_FLUSH = 2'b10;

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CH-1:0][DEPTH-1:0] stage;
  logic [CH-1:0]            out_next;
  logic [CW-1:0]            cnt [CH];

  logic is_hold;
  logic is_flush;

  assign is_hold  = (mode == MODE_HOLD);
  assign is_flush = (mode == MODE_FLUSH);

  // Pulse storage: shift in DELAY (and mode 11), freeze in HOLD, clear in FLUSH.
  // NOTE: state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the shift chain.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else if (is_flush) begin
      stage <= '0;
    end else if (!is_hold) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (k == 0) stage[c][k] <= in_pulse[c];
          else        stage[c][k] <= stage[c][k-1];
        end
      end
    end
  end

  // Next output pulse: last stage in DELAY/HOLD, nothing in FLUSH.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    out_next = '0;
    if (!is_flush) begin
      for (int c = 0; c < CH; c++) begin
        out_next[c] = stage[c][DEPTH-1];
      end
    end
  end

  // Registered output pulse.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) out_pulse <= '0;
    else        out_pulse <= out_next;
  end

  // Saturating emitted-pulse counters, advanced on the edge that registers a pulse.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) cnt[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (out_next[c] && (cnt[c] != CNT_MAX)) cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  // Sticky drop flags: an input arriving while the line cannot accept it.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) drop <= '0;
    else if (is_hold || is_flush) drop <= drop | in_pulse;
  end

  // Pack per-channel counters onto the flat output bus.
  always_comb begin
    out_cnt = '0;
    for (int c = 0; c < CH; c++) begin
      out_cnt[c*CW +: CW] = cnt[c];
    end
  end

  // Busy whenever any storage stage holds a pulse (reset clears the stages).
  assign busy = |stage;

endmodule
